// File: rtl/lcb_arb_pkg.sv
// lcb_arb_pkg: shared widths, RMW state enum and masked merge
// for the LCB frame-buffer write arbiter.
package lcb_arb_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 12;
    localparam int IDX_W      = 3;   // up to 8 requesters
    localparam int CNT_W      = 2;   // read latency up to 4

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_WRITE
    } arb_state_e;

    // Bits with mask=1 take the new data, the rest keep q.
    function automatic logic [31:0] merge_word(
        input logic [31:0] q,
        input logic [31:0] mask,
        input logic [31:0] data
    );
        return (q & ~mask) | (data & mask);
    endfunction

endpackage

// File: rtl/lcb_rr_pick.sv
// lcb_rr_pick: combinational round-robin picker.
// Ports: req (N), ptr (start index) -> any, one-hot grant, grant idx.
module lcb_rr_pick
    import lcb_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx
);

    int best;

    // Winner is the set bit with the smallest distance from ptr,
    // counting upward and wrapping modulo N.
    always_comb begin
        best = N;
        idx  = '0;
        for (int i = 0; i < N; i++) begin
            if (req[i] && ((i + N - int'(ptr)) % N) < best) begin
                best = (i + N - int'(ptr)) % N;
                idx  = IDX_W'(i);
            end
        end
    end

    assign any = |req;

    always_comb begin
        grant = '0;
        for (int i = 0; i < N; i++) begin
            grant[i] = any && (idx == IDX_W'(i));
        end
    end

endmodule

// File: rtl/lcb_buf_arbiter.sv
// lcb_buf_arbiter: round-robin masked read-modify-write arbiter that
// shares the LCB-side frame-buffer bank write port among N engines.
// Ports: clk, reset (sync, active-high); req/req_addr/req_data/req_mask
// in, ack out; mem_swch bank select in; mem_raddr/mem_rden/mem_q read
// side; mem_waddr/mem_wdata/mem_wren write side; busy out.
// Option: define FULL_WORD_BYPASS_EN to skip the read for full masks.
module lcb_buf_arbiter
    import lcb_arb_pkg::*;
#(
    parameter int N      = 4,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_LAT = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N-1:0]        req,
    input  logic [N*ADDR_W-1:0] req_addr,
    input  logic [N*DATA_W-1:0] req_data,
    input  logic [N*DATA_W-1:0] req_mask,
    output logic [N-1:0]        ack,
    input  logic                mem_swch,
    output logic [ADDR_W-1:0]   mem_raddr,
    output logic                mem_rden,
    input  logic [DATA_W-1:0]   mem_q,
    output logic [ADDR_W-1:0]   mem_waddr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic                mem_wren,
    output logic                busy
);

    arb_state_e state, state_nx;

    logic [IDX_W-1:0]  ptr;
    logic [IDX_W-1:0]  win_idx;
    logic [N-1:0]      win_oh;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_data;
    logic [DATA_W-1:0] lat_mask;
    logic              lat_swch;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] merged;

    logic              pick_any;
    logic [N-1:0]      pick_grant;
    logic [IDX_W-1:0]  pick_idx;

    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic [DATA_W-1:0] sel_mask;

    logic swap;
    logic do_latch;
    logic do_relatch;
    logic do_load;
    logic do_dec;
    logic do_capture;
    logic do_bypass;
    logic do_advance;

    lcb_rr_pick #(
        .N(N)
    ) u_pick (
        .req  (req),
        .ptr  (ptr),
        .any  (pick_any),
        .grant(pick_grant),
        .idx  (pick_idx)
    );

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        sel_mask = '0;
        for (int i = 0; i < N; i++) begin
            if (pick_grant[i]) begin
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                sel_data = req_data[i*DATA_W +: DATA_W];
                sel_mask = req_mask[i*DATA_W +: DATA_W];
            end
        end
    end

    // The other side swapped banks under us: restart on the new bank.
    assign swap = (state != ST_IDLE) && (mem_swch != lat_swch);

    always_comb begin
        state_nx   = state;
        do_latch   = 1'b0;
        do_relatch = 1'b0;
        do_load    = 1'b0;
        do_dec     = 1'b0;
        do_capture = 1'b0;
        do_bypass  = 1'b0;
        do_advance = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    do_latch = 1'b1;
                    state_nx = ST_READ;
`ifdef FULL_WORD_BYPASS_EN
                    if (&sel_mask) begin
                        do_bypass = 1'b1;
                        state_nx  = ST_WRITE;
                    end
`endif
                end
            end
            ST_READ: begin
                if (swap) begin
                    do_relatch = 1'b1;
                    state_nx   = ST_READ;
                end else begin
                    do_load  = 1'b1;
                    state_nx = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (swap) begin
                    do_relatch = 1'b1;
                    state_nx   = ST_READ;
                end else if (cnt == '0) begin
                    do_capture = 1'b1;
                    state_nx   = ST_WRITE;
                end else begin
                    do_dec = 1'b1;
                end
            end
            ST_WRITE: begin
                if (swap) begin
                    do_relatch = 1'b1;
                    state_nx   = ST_READ;
                end else begin
                    do_advance = 1'b1;
                    state_nx   = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            win_idx  <= '0;
            win_oh   <= '0;
            lat_addr <= '0;
            lat_data <= '0;
            lat_mask <= '0;
            lat_swch <= 1'b0;
            cnt      <= '0;
            merged   <= '0;
        end else begin
            state <= state_nx;
            if (do_latch) begin
                win_idx  <= pick_idx;
                win_oh   <= pick_grant;
                lat_addr <= sel_addr;
                lat_data <= sel_data;
                lat_mask <= sel_mask;
                lat_swch <= mem_swch;
            end
            if (do_bypass) begin
                merged <= sel_data;
            end
            if (do_relatch) begin
                lat_swch <= mem_swch;
            end
            if (do_load) begin
                cnt <= CNT_W'(RD_LAT - 1);
            end
            if (do_dec) begin
                cnt <= cnt - 1'b1;
            end
            if (do_capture) begin
                merged <= DATA_W'(merge_word(32'(mem_q),
                                             32'(lat_mask),
                                             32'(lat_data)));
            end
            if (do_advance) begin
                ptr <= (win_idx == IDX_W'(N - 1)) ? '0
                                                  : win_idx + 1'b1;
            end
        end
    end

    // Strobes are masked by reset so an interrupted write never lands.
    assign mem_rden  = (state == ST_READ) && !reset;
    assign mem_wren  = (state == ST_WRITE) && !swap && !reset;
    assign ack       = mem_wren ? win_oh : '0;
    assign mem_raddr = lat_addr;
    assign mem_waddr = lat_addr;
    assign mem_wdata = merged;
    assign busy      = (state != ST_IDLE);

endmodule
